// File: rtl/mbist_fail_logger.sv
// MBIST result collector: counts compare mismatches, logs {addr, syndrome} in a small FIFO,
// and publishes a pass/fail verdict. Optional per-address fail bitmap via MBIST_FAIL_BITMAP_EN.
module mbist_fail_logger #(
    parameter int unsigned ADDR_W    = 2,
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned LOG_DEPTH = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   cmp_valid,
    input  logic [ADDR_W-1:0]      cmp_addr,
    input  logic [DATA_W-1:0]      expected,
    input  logic [DATA_W-1:0]      actual,
    input  logic                   test_done,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [CNT_W-1:0]       fail_cnt,
    output logic                   overflow,
    output logic                   log_valid,
    output logic [ADDR_W-1:0]      log_addr,
    output logic [DATA_W-1:0]      log_syndrome,
`ifdef MBIST_FAIL_BITMAP_EN
    output logic [2**ADDR_W-1:0]   fail_map,
`endif
    input  logic                   log_ack
);

    localparam int unsigned PTR_W = $clog2(LOG_DEPTH);
    localparam int unsigned ENT_W = ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_REPORT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic               overflow_q, overflow_d;
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
    logic [ENT_W-1:0]   mem_q [LOG_DEPTH];
    logic [ENT_W-1:0]   mem_d [LOG_DEPTH];
`ifdef MBIST_FAIL_BITMAP_EN
    logic [2**ADDR_W-1:0] fail_map_q, fail_map_d;
`endif

    logic [DATA_W-1:0]  syndrome;
    logic               fail_ev;
    logic               fifo_empty;
    logic               fifo_full;
    logic [ENT_W-1:0]   head;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start always (re)enters COLLECT and wins over test_done
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (start) state_d = S_COLLECT;
            S_COLLECT: begin
                if (start)          state_d = S_COLLECT;
                else if (test_done) state_d = S_REPORT;
            end
            S_REPORT:  if (start) state_d = S_COLLECT;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fail_cnt_q <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_q      <= '{default: '0};
`ifdef MBIST_FAIL_BITMAP_EN
            fail_map_q <= '0;
`endif
        end else begin
            fail_cnt_q <= fail_cnt_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_q      <= mem_d;
`ifdef MBIST_FAIL_BITMAP_EN
            fail_map_q <= fail_map_d;
`endif
        end
    end

    assign syndrome   = expected ^ actual;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    // A compare coinciding with a restart is discarded
    assign fail_ev    = (state_q == S_COLLECT) && !start && cmp_valid && (|syndrome);

    // Counter, overflow flag and FIFO update
    always_comb begin
        fail_cnt_d = fail_cnt_q;
        overflow_d = overflow_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_d      = mem_q;
`ifdef MBIST_FAIL_BITMAP_EN
        fail_map_d = fail_map_q;
`endif
        if (start) begin
            fail_cnt_d = '0;
            overflow_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
`ifdef MBIST_FAIL_BITMAP_EN
            fail_map_d = '0;
`endif
        end else begin
            if (fail_ev) begin
                if (fail_cnt_q != {CNT_W{1'b1}}) begin
                    fail_cnt_d = fail_cnt_q + CNT_W'(1);
                end
                if (!fifo_full) begin
                    mem_d[wr_ptr_q[PTR_W-1:0]] = {cmp_addr, syndrome};
                    wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
                end else begin
                    overflow_d = 1'b1;
                end
`ifdef MBIST_FAIL_BITMAP_EN
                fail_map_d[cmp_addr] = 1'b1;
`endif
            end
            if ((state_q == S_REPORT) && log_ack && !fifo_empty) begin
                rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
            end
        end
    end

    assign head = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Outputs decoded from registered state and FIFO contents only
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        log_valid    = 1'b0;
        log_addr     = '0;
        log_syndrome = '0;
        if (state_q == S_COLLECT) busy = 1'b1;
        if (state_q == S_REPORT) begin
            done      = 1'b1;
            log_valid = !fifo_empty;
        end
        if (log_valid) begin
            log_addr     = head[ENT_W-1:DATA_W];
            log_syndrome = head[DATA_W-1:0];
        end
        pass = done && (fail_cnt_q == '0);
    end

    assign fail_cnt = fail_cnt_q;
    assign overflow = overflow_q;
`ifdef MBIST_FAIL_BITMAP_EN
    assign fail_map = fail_map_q;
`endif

endmodule

// File: tb/tb_mbist_fail_logger.sv
// Scoreboard bench for mbist_fail_logger: stimulus queues expected verdicts and log entries,
// a negedge monitor checks them when done rises or a log entry is acknowledged.
module tb_mbist_fail_logger;

    typedef struct packed {
        logic       pass;
        logic [7:0] cnt;
        logic       ovf;
    } verdict_t;

    typedef struct packed {
        logic [1:0] addr;
        logic [3:0] syn;
    } entry_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       cmp_valid;
    logic [1:0] cmp_addr;
    logic [3:0] expected;
    logic [3:0] actual;
    logic       test_done;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] fail_cnt;
    logic       overflow;
    logic       log_valid;
    logic [1:0] log_addr;
    logic [3:0] log_syndrome;
    logic       log_ack;
`ifdef MBIST_FAIL_BITMAP_EN
    logic [3:0] fail_map;
`endif

    int unsigned vectors = 0;
    int unsigned errors  = 0;
    verdict_t    verdict_q[$];
    entry_t      log_q[$];
    logic        done_prev = 1'b0;

    mbist_fail_logger #(
        .ADDR_W(2), .DATA_W(4), .LOG_DEPTH(4), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cmp_valid(cmp_valid),
        .cmp_addr(cmp_addr), .expected(expected), .actual(actual),
        .test_done(test_done), .busy(busy), .done(done), .pass(pass),
        .fail_cnt(fail_cnt), .overflow(overflow), .log_valid(log_valid),
        .log_addr(log_addr), .log_syndrome(log_syndrome),
`ifdef MBIST_FAIL_BITMAP_EN
        .fail_map(fail_map),
`endif
        .log_ack(log_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: verdict on each rising done, entry on each accepted pop
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (verdict_q.size() == 0) begin
                chk("unexpected_verdict", 1, 0);
            end else begin
                verdict_t v;
                v = verdict_q.pop_front();
                chk("verdict_pass", 32'(pass), 32'(v.pass));
                chk("verdict_fail_cnt", 32'(fail_cnt), 32'(v.cnt));
                chk("verdict_overflow", 32'(overflow), 32'(v.ovf));
            end
        end
        if (log_valid && log_ack) begin
            if (log_q.size() == 0) begin
                chk("unexpected_log_entry", 1, 0);
            end else begin
                entry_t e;
                e = log_q.pop_front();
                chk("log_addr", 32'(log_addr), 32'(e.addr));
                chk("log_syndrome", 32'(log_syndrome), 32'(e.syn));
            end
        end
        done_prev = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input logic [1:0] a, input logic [3:0] e, input logic [3:0] r,
                       input logic td);
        cmp_valid = 1'b1;
        cmp_addr  = a;
        expected  = e;
        actual    = r;
        test_done = td;
        tick();
        cmp_valid = 1'b0;
        test_done = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
    endtask

    task automatic finish_test();
        test_done = 1'b1;
        tick();
        test_done = 1'b0;
        chk("done_after_test_done", 32'(done), 1);
        @(negedge clk);
        tick();
    endtask

    task automatic drain();
        int guard = 0;
        while (log_valid && guard < 12) begin
            log_ack = 1'b1;
            tick();
            log_ack = 1'b0;
            guard++;
        end
        chk("log_valid_after_drain", 32'(log_valid), 0);
        chk("log_entries_consumed", 32'(log_q.size()), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
        chk({tag, "_fail_cnt"}, 32'(fail_cnt), 0);
        chk({tag, "_overflow"}, 32'(overflow), 0);
        chk({tag, "_log_valid"}, 32'(log_valid), 0);
        chk({tag, "_log_addr"}, 32'(log_addr), 0);
        chk({tag, "_log_syndrome"}, 32'(log_syndrome), 0);
`ifdef MBIST_FAIL_BITMAP_EN
        chk({tag, "_fail_map"}, 32'(fail_map), 0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; cmp_valid = 1'b0; cmp_addr = '0;
        expected = '0; actual = '0; test_done = 1'b0; log_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        // IDLE ignores compares and test_done
        cmp(2'd1, 4'hF, 4'h0, 1'b1);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(done), 0);
        chk("idle_fail_cnt", 32'(fail_cnt), 0);

        // All-pass run
        go();
        for (int i = 0; i < 8; i++) cmp(2'(i), 4'(i + 3), 4'(i + 3), 1'b0);
        verdict_q.push_back('{pass: 1'b1, cnt: 8'd0, ovf: 1'b0});
        finish_test();
        chk("allpass_log_valid", 32'(log_valid), 0);
        log_ack = 1'b1;
        tick();
        log_ack = 1'b0;
        chk("ack_when_empty_done", 32'(done), 1);
        chk("ack_when_empty_log_valid", 32'(log_valid), 0);

        // Single failure at addr 2: A ^ 8 = 2
        go();
        cmp(2'd2, 4'hA, 4'h8, 1'b0);
        verdict_q.push_back('{pass: 1'b0, cnt: 8'd1, ovf: 1'b0});
        log_q.push_back('{addr: 2'd2, syn: 4'h2});
        finish_test();
        chk("single_log_valid", 32'(log_valid), 1);
        drain();

        // Six failures overflow a 4-deep log
        go();
        for (int i = 0; i < 6; i++) begin
            cmp(2'(i % 4), 4'hF, 4'(i), 1'b0);
            if (i < 4) log_q.push_back('{addr: 2'(i), syn: 4'hF ^ 4'(i)});
        end
        verdict_q.push_back('{pass: 1'b0, cnt: 8'd6, ovf: 1'b1});
        finish_test();
        drain();

        // Failure coincident with test_done is still logged
        go();
        log_q.push_back('{addr: 2'd3, syn: 4'h1});
        verdict_q.push_back('{pass: 1'b0, cnt: 8'd1, ovf: 1'b0});
        cmp(2'd3, 4'h5, 4'h4, 1'b1);
        chk("same_cycle_done", 32'(done), 1);
        @(negedge clk);
        tick();
        drain();

        // Restart mid-collect discards earlier failures and the coincident compare
        go();
        cmp(2'd0, 4'h1, 4'h0, 1'b0);
        cmp(2'd1, 4'h2, 4'h0, 1'b0);
        chk("pre_restart_fail_cnt", 32'(fail_cnt), 2);
        start = 1'b1;
        cmp(2'd2, 4'h3, 4'h0, 1'b0);
        start = 1'b0;
        chk("restart_fail_cnt", 32'(fail_cnt), 0);
        chk("restart_busy", 32'(busy), 1);
        cmp(2'd3, 4'h5, 4'h5, 1'b0);
        verdict_q.push_back('{pass: 1'b1, cnt: 8'd0, ovf: 1'b0});
        finish_test();
        chk("restart_log_valid", 32'(log_valid), 0);

        // Counter saturates at all-ones
        go();
        for (int i = 0; i < 260; i++) begin
            cmp(2'(i % 4), 4'hF, 4'h0, 1'b0);
            if (i < 4) log_q.push_back('{addr: 2'(i), syn: 4'hF});
        end
        verdict_q.push_back('{pass: 1'b0, cnt: 8'd255, ovf: 1'b1});
        finish_test();
        drain();

        // Reset in REPORT with entries pending
        go();
        cmp(2'd1, 4'h6, 4'h2, 1'b0);
        cmp(2'd1, 4'h6, 4'h7, 1'b0);
        cmp(2'd3, 4'h0, 4'h8, 1'b0);
        verdict_q.push_back('{pass: 1'b0, cnt: 8'd3, ovf: 1'b0});
        finish_test();
        chk("pending_log_valid", 32'(log_valid), 1);
`ifdef MBIST_FAIL_BITMAP_EN
        chk("fail_map", 32'(fail_map), 32'h0000_000A);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("report_reset");

        chk("verdicts_consumed", 32'(verdict_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
